// File: rtl/pc_call_stack_pkg.sv
// Shared definitions for the program counter / return-address stack.
//
// The J_* macros are the next-PC source codes that the control unit drives
// on j_mode. They live beside the control-unit macros, with one `define per
// code. The package wraps the same codes in an enum so that the RTL can use
// typed case labels.
`ifndef PC_CALL_STACK_DEFS
`define PC_CALL_STACK_DEFS
`define J_NEXT 2'b00
`define J_IMM  2'b01
`define J_RET  2'b10
`define J_COND 2'b11
`endif

package pc_call_stack_pkg;

    // Next-PC source select, as driven by the control unit
    typedef enum logic [1:0] {
        JM_NEXT = `J_NEXT,
        JM_IMM  = `J_IMM,
        JM_RET  = `J_RET,
        JM_COND = `J_COND
    } j_mode_e;

endpackage

// File: rtl/pc_call_stack_return_stack.sv
// DEPTH x ADDR_W LIFO holding the return addresses.
//
// Ports:
//   clk, rst   rising-edge clock; asynchronous, active-high reset (clears only sp)
//   push, pop  stack operations; the top never asserts both together
//   din        value to push
//   dout       current top-of-stack entry (stack[sp-1]); only meaningful when !empty
//   sp         occupancy, 0..DEPTH
//   full       sp == DEPTH
//   empty      sp == 0
//   ovf_evt    push requested while full (combinational event)
//   unf_evt    pop requested while empty (combinational event)
module pc_call_stack_return_stack #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 8,
    parameter int SP_W   = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] din,
    output logic [ADDR_W-1:0] dout,
    output logic [SP_W-1:0]   sp,
    output logic              full,
    output logic              empty,
    output logic              ovf_evt,
    output logic              unf_evt
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [ADDR_W-1:0] mem [DEPTH];
    logic [SP_W-1:0]   sp_q;
    logic [SP_W-1:0]   sp_d;
    logic [SP_W-1:0]   sp_dec;
    logic              wr_en;
    logic              rd_en;

    // A rejected push or pop leaves sp untouched and is only reported as an event
    always_comb begin
        full    = (sp_q == SP_W'(DEPTH));
        empty   = (sp_q == '0);
        wr_en   = push & ~full;
        rd_en   = pop & ~empty;
        ovf_evt = push & full;
        unf_evt = pop & empty;
        sp_dec  = sp_q - SP_W'(1);
        dout    = mem[sp_dec[IDX_W-1:0]];
        sp_d    = sp_q;
        if (wr_en) begin
            sp_d = sp_q + SP_W'(1);
        end else if (rd_en) begin
            sp_d = sp_dec;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
    end

    // The storage array has no reset: an entry is only ever read after it
    // has been written, because sp guards every read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[sp_q[IDX_W-1:0]] <= din;
        end
    end

    assign sp = sp_q;

endmodule

// File: rtl/pc_call_stack.sv
// Program counter with a hardware return-address stack. This block sits
// directly downstream of the control unit.
//
// Ports:
//   i_clk, i_rst  clock; asynchronous, active-high reset
//   i_jump        qualifies j_mode=J_IMM
//   i_j_mode      next-PC source: J_NEXT / J_IMM / J_RET / J_COND
//   i_call        push PC+1 onto the return stack
//   i_return      pop the return stack into o_ret_addr
//   i_PCw         PC write enable
//   i_target      jump/call target
//   i_cond        branch condition for J_COND
//   o_pc          current fetch address
//   o_ret_addr    last popped return address
//   o_sp          stack occupancy
//   o_full        stack is full
//   o_empty       stack is empty
//   o_ovf         sticky flag: push attempted while the stack was full
//   o_unf         sticky flag: pop attempted while the stack was empty
//   o_err         one-cycle pulse: call and return were requested together
module pc_call_stack
    import pc_call_stack_pkg::*;
#(
    parameter int                ADDR_W    = 8,
    parameter int                DEPTH     = 8,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter int                SP_W      = $clog2(DEPTH) + 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_jump,
    input  logic [1:0]        i_j_mode,
    input  logic              i_call,
    input  logic              i_return,
    input  logic              i_PCw,
    input  logic [ADDR_W-1:0] i_target,
    input  logic              i_cond,
    output logic [ADDR_W-1:0] o_pc,
    output logic [ADDR_W-1:0] o_ret_addr,
    output logic [SP_W-1:0]   o_sp,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_ovf,
    output logic              o_unf,
    output logic              o_err
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] ret_addr_q, ret_addr_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              err_q, err_d;

    logic [ADDR_W-1:0] pc_inc;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] stk_dout;
    logic              stk_empty;
    logic              ovf_evt;
    logic              unf_evt;

    // A simultaneous call and return is treated as a conflict: the stack is
    // left alone and only the error pulse is raised.
    always_comb begin
        push   = i_call & ~i_return;
        pop    = i_return & ~i_call;
        pc_inc = pc_q + ADDR_W'(1);
    end

    pc_call_stack_return_stack #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .SP_W   (SP_W)
    ) u_return_stack (
        .clk     (i_clk),
        .rst     (i_rst),
        .push    (push),
        .pop     (pop),
        .din     (pc_inc),
        .dout    (stk_dout),
        .sp      (o_sp),
        .full    (o_full),
        .empty   (stk_empty),
        .ovf_evt (ovf_evt),
        .unf_evt (unf_evt)
    );

    // The PC update is independent of call/return. The control unit sequences
    // a return as a pop edge followed by a J_RET edge, so J_RET always reads
    // the registered return address rather than the stack itself.
    always_comb begin
        pc_d = pc_q;
        if (i_PCw) begin
            unique case (j_mode_e'(i_j_mode))
                JM_NEXT: pc_d = pc_inc;
                JM_IMM:  pc_d = i_jump ? i_target : pc_inc;
                JM_RET:  pc_d = ret_addr_q;
                JM_COND: pc_d = i_cond ? i_target : pc_inc;
                default: pc_d = pc_inc;
            endcase
        end

        ret_addr_d = ret_addr_q;
        if (pop) begin
            ret_addr_d = stk_empty ? '0 : stk_dout;
        end

        ovf_d = ovf_q | ovf_evt;
        unf_d = unf_q | unf_evt;
        err_d = i_call & i_return;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pc_q       <= RESET_VEC;
            ret_addr_q <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            ret_addr_q <= ret_addr_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            err_q      <= err_d;
        end
    end

    assign o_pc       = pc_q;
    assign o_ret_addr = ret_addr_q;
    assign o_empty    = stk_empty;
    assign o_ovf      = ovf_q;
    assign o_unf      = unf_q;
    assign o_err      = err_q;

endmodule
